// File: rtl/div_iter_if.sv
// Request/result bundle between the execute stage and the iterative divider div_iter.
interface div_iter_if #(
    parameter int XLEN = 32
);
    logic                req_i;
    logic [XLEN-1:0]     a_i;
    logic [XLEN-1:0]     b_i;
    logic                ready_o;
    logic [2*XLEN-1:0]   result_o;

    modport master (
        output req_i,
        output a_i,
        output b_i,
        input  ready_o,
        input  result_o
    );

    modport slave (
        input  req_i,
        input  a_i,
        input  b_i,
        output ready_o,
        output result_o
    );
endinterface

// File: rtl/div_iter.sv
// Unsigned restoring divider, one quotient bit per cycle; result = {remainder, quotient}.
// Optional macro DIV_FAST_ZERO_EN: a zero divisor completes directly from IDLE.
module div_iter #(
    parameter int XLEN = 32
) (
    input  logic      clk_i,
    input  logic      rst_i,
    div_iter_if.slave bus
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [XLEN-1:0]     dvd_r;
    logic [XLEN-1:0]     dvd_s;
    logic [XLEN-1:0]     dvs_r;
    logic [XLEN-1:0]     dvs_s;
    logic [XLEN-1:0]     rem_r;
    logic [XLEN-1:0]     rem_s;
    logic [CW-1:0]       cnt_r;
    logic [CW-1:0]       cnt_s;
    logic                ready_r;
    logic [2*XLEN-1:0]   result_r;
    logic [2*XLEN-1:0]   result_s;
    logic [XLEN:0]       rem_shift_s;
    logic                ge_s;
    logic [XLEN-1:0]     step_rem_s;
    logic [XLEN-1:0]     step_quo_s;

    // One restoring step. The compare spans XLEN+1 bits so the shifted-out MSB is kept;
    // the difference is always below the divisor, so its low XLEN bits are exact.
    always_comb begin
        rem_shift_s = {rem_r, dvd_r[XLEN-1]};
        ge_s        = (rem_shift_s >= {1'b0, dvs_r});
        if (ge_s) begin
            step_rem_s = rem_shift_s[XLEN-1:0] - dvs_r;
        end else begin
            step_rem_s = rem_shift_s[XLEN-1:0];
        end
        step_quo_s = {dvd_r[XLEN-2:0], ge_s};
    end

    // Next-state and datapath-load decisions; dvd_r doubles as the quotient shift register
    always_comb begin
        state_s  = state_r;
        dvd_s    = dvd_r;
        dvs_s    = dvs_r;
        rem_s    = rem_r;
        cnt_s    = cnt_r;
        result_s = result_r;
        case (state_r)
            IDLE: begin
                if (bus.req_i) begin
                    dvd_s = bus.a_i;
                    dvs_s = bus.b_i;
                    rem_s = '0;
                    cnt_s = CW'(XLEN);
`ifdef DIV_FAST_ZERO_EN
                    if (bus.b_i == '0) begin
                        state_s  = DONE;
                        cnt_s    = '0;
                        result_s = {bus.a_i, {XLEN{1'b1}}};
                    end else begin
                        state_s = BUSY;
                    end
`else
                    state_s = BUSY;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (!bus.req_i) begin
                    state_s = IDLE;
                end else begin
                    dvd_s = step_quo_s;
                    rem_s = step_rem_s;
                    cnt_s = cnt_r - CW'(1);
                    if (cnt_r == CW'(1)) begin
                        state_s  = DONE;
                        result_s = {step_rem_s, step_quo_s};
                    end else begin
                        state_s = BUSY;
                    end
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, working registers and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= IDLE;
            dvd_r    <= '0;
            dvs_r    <= '0;
            rem_r    <= '0;
            cnt_r    <= '0;
            ready_r  <= 1'b0;
            result_r <= '0;
        end else begin
            state_r  <= state_s;
            dvd_r    <= dvd_s;
            dvs_r    <= dvs_s;
            rem_r    <= rem_s;
            cnt_r    <= cnt_s;
            ready_r  <= (state_s == DONE);
            result_r <= result_s;
        end
    end

    assign bus.ready_o  = ready_r;
    assign bus.result_o = result_r;
endmodule

// File: tb/tb_div_iter.sv
// Randomized self-checking bench for div_iter against a cycle-tagged arithmetic model.
module tb_div_iter;
    localparam int XLEN = 32;
`ifdef DIV_FAST_ZERO_EN
    localparam bit FAST_ZERO = 1'b1;
`else
    localparam bit FAST_ZERO = 1'b0;
`endif

    typedef struct {
        int                cyc;
        logic [2*XLEN-1:0] res;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    div_iter_if #(.XLEN(XLEN)) bus ();
    div_iter #(.XLEN(XLEN)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Model state: written by the driver only
    exp_t              exp_q[$];
    int                free_edge = 0;
    logic              chk_en = 1'b0;
    int                chk_cyc = -1;
    logic [2*XLEN-1:0] chk_val = '0;
    int                pin_cyc = -1;

    // Checker state: written by the compare process only
    int                vectors = 0;
    int                miscompares = 0;
    logic [2*XLEN-1:0] last_result = '0;

    function automatic logic [2*XLEN-1:0] ref_div(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        if (b == '0) return {a, {XLEN{1'b1}}};
        return {a % b, a / b};
    endfunction

    task automatic chk(input string name, input logic [2*XLEN-1:0] act, input logic [2*XLEN-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Compare process: ready_o every cycle, result_o on ready and at tagged cycles
    always @(negedge clk) begin
        if (chk_en) begin
            logic              exp_rdy;
            logic [2*XLEN-1:0] exp_res;
            exp_rdy = 1'b0;
            exp_res = '0;
            foreach (exp_q[i]) begin
                if (exp_q[i].cyc == cyc) begin
                    exp_rdy = 1'b1;
                    exp_res = exp_q[i].res;
                end
            end
            chk("ready_o", {{(2*XLEN-1){1'b0}}, bus.ready_o}, {{(2*XLEN-1){1'b0}}, exp_rdy});
            if (exp_rdy) begin
                chk("result_o", bus.result_o, exp_res);
                last_result = exp_res;
            end
            if (cyc == chk_cyc) begin
                chk("result_hold", bus.result_o, chk_val);
                last_result = chk_val;
            end
            if (cyc == pin_cyc) begin
                chk("model_100_7", ref_div(32'd100, 32'd7), 64'h0000_0002_0000_000E);
                chk("model_50_6", ref_div(32'd50, 32'd6), 64'h0000_0002_0000_0008);
                chk("model_max_1", ref_div(32'hFFFF_FFFF, 32'd1), 64'h0000_0000_FFFF_FFFF);
                chk("model_5_max", ref_div(32'd5, 32'hFFFF_FFFF), 64'h0000_0005_0000_0000);
                chk("model_div0", ref_div(32'h0000_1234, 32'd0), 64'h0000_1234_FFFF_FFFF);
                chk("model_9_3", ref_div(32'd9, 32'd3), 64'h0000_0000_0000_0003);
            end
        end
    end

    // Raise a request at this negedge; returns the sampling edge and the expected ready cycle
    task automatic start_div(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                             output int e, output int rdy);
        int lat;
        e = (cyc + 1 > free_edge) ? cyc + 1 : free_edge;
        lat = (FAST_ZERO && b == '0) ? 0 : XLEN;
        rdy = e + lat;
        bus.req_i = 1'b1;
        bus.a_i   = a;
        bus.b_i   = b;
        exp_q.push_back('{cyc: rdy, res: ref_div(a, b)});
        free_edge = rdy + 2;
    endtask

    // Full division with req held; operands are scrambled while the divider works
    task automatic run_div(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input bit wiggle);
        int e;
        int rdy;
        start_div(a, b, e, rdy);
        while (cyc < rdy) begin
            @(negedge clk);
            if (wiggle && cyc >= e && cyc < rdy) begin
                bus.a_i = $urandom;
                bus.b_i = $urandom;
            end
        end
    endtask

    task automatic drop_req();
        bus.req_i = 1'b0;
        bus.a_i   = $urandom;
        bus.b_i   = $urandom;
    endtask

    // Start a division and cut it off at the given BUSY cycle, by req drop or by reset
    task automatic cut_div(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input int busy_cyc, input bit use_rst);
        int e;
        int rdy;
        start_div(a, b, e, rdy);
        while (cyc < e + busy_cyc - 1) @(negedge clk);
        void'(exp_q.pop_back());
        bus.req_i = 1'b0;
        chk_cyc   = cyc + 1;
        if (use_rst) begin
            rst     = 1'b1;
            chk_val = '0;
        end else begin
            chk_val = last_result;
        end
        free_edge = cyc + 2;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [XLEN-1:0] ra;
        logic [XLEN-1:0] rb;
        rst       = 1'b1;
        bus.req_i = 1'b0;
        bus.a_i   = '0;
        bus.b_i   = '0;
        repeat (2) @(negedge clk);
        chk_en  = 1'b1;
        chk_val = '0;
        chk_cyc = cyc + 1;
        pin_cyc = cyc + 1;
        @(negedge clk);
        rst = 1'b0;

        run_div(32'd100, 32'd7, 1'b1);
        run_div(32'd50, 32'd6, 1'b1);
        drop_req();
        @(negedge clk);
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0);
        run_div(32'd5, 32'hFFFF_FFFF, 1'b1);
        drop_req();
        repeat (2) @(negedge clk);
        run_div(32'h0000_1234, 32'd0, 1'b1);
        drop_req();
        @(negedge clk);
        cut_div(32'd77, 32'd5, 10, 1'b0);
        run_div(32'd9, 32'd3, 1'b1);
        drop_req();
        @(negedge clk);
        cut_div(32'd1000, 32'd3, 20, 1'b1);
        run_div(32'd100, 32'd7, 1'b0);
        drop_req();

        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = XLEN'($urandom_range(1, 15));
                2:       rb = $urandom;
                default: rb = ra >> $urandom_range(0, XLEN - 1);
            endcase
            run_div(ra, rb, 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                drop_req();
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        drop_req();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
